// File: rtl/tiny_cpu.sv
// Minimal 8-bit CPU demo top: 16-byte ROM, 16 x 8-bit registers (R0 = 0), 4-bit PC, one instruction per divided tick.
// Optional build macro TINY_CPU_LED_ACTIVE_LOW_EN inverts the three LED outputs for active-low boards.
module tiny_cpu #(
  parameter int    CLK_DIV_LOG2  = 2,
  parameter string ROM_INIT_FILE = ""
) (
  input  logic CLK,
  input  logic RST,
  output logic led_red,
  output logic led_green,
  output logic led_blue
);

  // Built-in loop program at addresses 0-4; remaining addresses hold HALT.
  function automatic logic [15:0][7:0] rom_init();
    logic [7:0]       mem [16];
    logic [15:0][7:0] img;
    for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
    mem[0] = 8'h00;
    mem[1] = 8'h11;
    mem[2] = 8'h12;
    mem[3] = 8'h13;
    mem[4] = 8'h82;
    for (int i = 0; i < 16; i++) img[i] = mem[i];
    return img;
  endfunction

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_DEC  = 4'h2;
  localparam logic [3:0] OP_CLR  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BNZ  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [15:0][7:0]        ROM = rom_init();
  logic [7:0]              R [16];
  logic [3:0]              PC;
  logic                    slow_clk;
  logic [CLK_DIV_LOG2-1:0] r_div;
  logic                    r_halted;

  logic       w_strobe;
  logic [7:0] w_instr;
  logic [3:0] w_op;
  logic [3:0] w_n;
  logic [7:0] w_rn;
  logic [7:0] w_r1;
  logic       w_we;
  logic [7:0] w_wdata;
  logic [3:0] w_next_pc;
  logic [2:0] w_led;

  assign slow_clk = r_div[CLK_DIV_LOG2-1];
  assign w_strobe = &r_div;
  assign w_instr  = ROM[PC];
  assign w_op     = w_instr[7:4];
  assign w_n      = w_instr[3:0];
  assign w_rn     = R[w_n];
  assign w_r1     = R[1];

  always_comb begin
    w_we      = 1'b0;
    w_wdata   = w_rn;
    w_next_pc = PC + 4'd1;
    case (w_op)
      OP_NOP: ;
      OP_INC: begin w_we = 1'b1; w_wdata = w_rn + 8'd1;  end
      OP_DEC: begin w_we = 1'b1; w_wdata = w_rn - 8'd1;  end
      OP_CLR: begin w_we = 1'b1; w_wdata = 8'h00;        end
      OP_NOT: begin w_we = 1'b1; w_wdata = ~w_rn;        end
      OP_SHL: begin w_we = 1'b1; w_wdata = w_rn << 1;    end
      OP_SHR: begin w_we = 1'b1; w_wdata = w_rn >> 1;    end
      OP_ADD: begin w_we = 1'b1; w_wdata = w_rn + w_r1;  end
      OP_JMP: w_next_pc = w_n;
      OP_BNZ: if (w_r1 != 8'h00) w_next_pc = w_n;
      OP_BZ:  if (w_r1 == 8'h00) w_next_pc = w_n;
      OP_HALT: w_next_pc = PC;
      default: ;
    endcase
  end

  // State advances only on the divider wrap edge; a halted core keeps PC and R frozen until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div    <= '0;
      PC       <= 4'd0;
      r_halted <= 1'b0;
      for (int i = 0; i < 16; i++) R[i] <= 8'h00;
    end else begin
      r_div <= r_div + 1'b1;
      if (w_strobe && !r_halted) begin
        PC <= w_next_pc;
        if (w_op == OP_HALT) r_halted <= 1'b1;
        if (w_we && (w_n != 4'd0)) R[w_n] <= w_wdata;
      end
    end
  end

  assign w_led = w_rn[2:0];

`ifdef TINY_CPU_LED_ACTIVE_LOW_EN
  assign {led_red, led_green, led_blue} = ~w_led;
`else
  assign {led_red, led_green, led_blue} = w_led;
`endif

endmodule

// File: tb/tb_tiny_cpu.sv
// Directed bench for tiny_cpu: reset, default loop program, wrap/halt, branches, R0 writes, ALU ops, mid-run reset.
module tb_tiny_cpu;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic led_red, led_green, led_blue;

   int checks = 0;
   int errors = 0;
   bit r0_watch = 1'b0;

   logic [7:0] def_rom [16];
   logic [7:0] prog    [16];
   logic [7:0] exp_r   [16];
   logic [3:0] exp_pc;

   tiny_cpu #(.CLK_DIV_LOG2(2)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .led_red   (led_red),
      .led_green (led_green),
      .led_blue  (led_blue)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] led_exp(input logic [2:0] v);
`ifdef TINY_CPU_LED_ACTIVE_LOW_EN
      return {5'b0, ~v};
`else
      return {5'b0, v};
`endif
   endfunction

   function automatic logic [7:0] leds();
      return {5'b0, led_red, led_green, led_blue};
   endfunction

   always @(negedge CLK) if (r0_watch) check("r0_zero", dut.R[0], 8'h00);

   task automatic load_and_reset(input logic [7:0] p [16]);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 16; i++) dut.ROM[i] = p[i];
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic step();
      repeat (4) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic fill_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
   endtask

   initial begin
      logic [7:0] br_pc  [7];
      logic [7:0] br_r1  [7];
      logic [7:0] br_led [7];
      logic [7:0] op_r6  [11];
      logic [7:0] op_led [11];

      for (int i = 0; i < 16; i++) def_rom[i] = 8'hF0;
      def_rom[0] = 8'h00; def_rom[1] = 8'h11; def_rom[2] = 8'h12;
      def_rom[3] = 8'h13; def_rom[4] = 8'h82;

      // Reset held for two clocks
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_pc", {4'h0, dut.PC}, 8'h00);
      for (int i = 0; i < 16; i++) check($sformatf("rst_r%0d", i), dut.R[i], 8'h00);
      check("rst_leds", leds(), led_exp(3'b000));
      r0_watch = 1'b1;
      RST = 1'b0;

      // Default program, 50 clocks
      exp_pc = 4'd0;
      for (int i = 0; i < 16; i++) exp_r[i] = 8'h00;
      for (int e = 1; e <= 50; e++) begin
         @(posedge CLK);
         if (e % 4 == 0) begin
            case (def_rom[exp_pc][7:4])
               4'h1: begin exp_r[def_rom[exp_pc][3:0]]++; exp_pc = exp_pc + 4'd1; end
               4'h8: exp_pc = def_rom[exp_pc][3:0];
               default: exp_pc = exp_pc + 4'd1;
            endcase
         end
         @(negedge CLK);
         check("def_pc", {4'h0, dut.PC}, {4'h0, exp_pc});
         check("def_slow_clk", {7'h0, dut.slow_clk}, {7'h0, ((e % 4) >= 2)});
         check("def_leds", leds(), led_exp(exp_r[def_rom[exp_pc][3:0]][2:0]));
         if (exp_pc == 4'd3) check("def_r1_at_pc3", dut.R[1], 8'h01);
      end
      check("def_r2", dut.R[2], exp_r[2]);
      check("def_r3", dut.R[3], exp_r[3]);

      // Wrap: DEC R5 then HALT
      fill_prog();
      prog[0] = 8'h25; prog[1] = 8'hF5;
      load_and_reset(prog);
      step();
      check("wrap_pc", {4'h0, dut.PC}, 8'h01);
      check("wrap_r5", dut.R[5], 8'hFF);
      check("wrap_leds", leds(), led_exp(3'b111));
      for (int k = 0; k < 21; k++) begin
         step();
         check("halt_pc", {4'h0, dut.PC}, 8'h01);
         check("halt_r5", dut.R[5], 8'hFF);
         check("halt_leds", leds(), led_exp(3'b111));
      end

      // Branches: BZ taken, INC x3, BNZ taken, BZ not taken, HALT
      fill_prog();
      prog[0] = 8'hA7; prog[7] = 8'h11; prog[8] = 8'h11; prog[9] = 8'h11;
      prog[10] = 8'h9D; prog[13] = 8'hA0; prog[14] = 8'hF0;
      br_pc  = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd14};
      br_r1  = '{8'd0, 8'd1, 8'd2, 8'd3,  8'd3,  8'd3,  8'd3};
      br_led = '{8'd0, 8'd1, 8'd2, 8'd0,  8'd0,  8'd0,  8'd0};
      load_and_reset(prog);
      for (int k = 0; k < 7; k++) begin
         step();
         check($sformatf("br_pc_%0d", k), {4'h0, dut.PC}, br_pc[k]);
         check($sformatf("br_r1_%0d", k), dut.R[1], br_r1[k]);
         check($sformatf("br_leds_%0d", k), leds(), led_exp(br_led[k][2:0]));
      end

      // Writes to R0 are dropped
      fill_prog();
      prog[0] = 8'h10; prog[1] = 8'h40; prog[2] = 8'hF0;
      load_and_reset(prog);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("r0w_pc_%0d", k), {4'h0, dut.PC}, (k == 0) ? 8'd1 : 8'd2);
         check($sformatf("r0w_r0_%0d", k), dut.R[0], 8'h00);
         check($sformatf("r0w_leds_%0d", k), leds(), led_exp(3'b000));
      end

      // ALU ops on R6 with R1 = 1, reserved opcode at 9, HALT at 10
      fill_prog();
      prog[0] = 8'h11; prog[1] = 8'h76; prog[2] = 8'h56; prog[3] = 8'h56;
      prog[4] = 8'h46; prog[5] = 8'h66; prog[6] = 8'h36; prog[7] = 8'h26;
      prog[8] = 8'h16; prog[9] = 8'hB6; prog[10] = 8'hF6;
      op_r6  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'hFB, 8'h7D, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
      op_led = '{8'd0,  8'd1,  8'd2,  8'd4,  8'd3,  8'd5,  8'd0,  8'd7,  8'd0,  8'd0,  8'd0};
      load_and_reset(prog);
      for (int k = 0; k < 11; k++) begin
         step();
         check($sformatf("op_pc_%0d", k), {4'h0, dut.PC}, (k < 10) ? 8'(k + 1) : 8'd10);
         check($sformatf("op_r6_%0d", k), dut.R[6], op_r6[k]);
         check($sformatf("op_leds_%0d", k), leds(), led_exp(op_led[k][2:0]));
      end

      // Reset landing on an execute-strobe edge
      load_and_reset(def_rom);
      step();
      step();
      check("mid_pc_before", {4'h0, dut.PC}, 8'h02);
      check("mid_r1_before", dut.R[1], 8'h01);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("mid_pc", {4'h0, dut.PC}, 8'h00);
      check("mid_r1", dut.R[1], 8'h00);
      check("mid_r2", dut.R[2], 8'h00);
      check("mid_leds", leds(), led_exp(3'b000));
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("mid_pc_wait", {4'h0, dut.PC}, 8'h00);
      @(posedge CLK);
      @(negedge CLK);
      check("mid_pc_first", {4'h0, dut.PC}, 8'h01);

      r0_watch = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
